stream_mux_rr: RTL
==================

// Module: stream_mux_rr
//
// PURPOSE
//   Parametrised N-channel stream multiplexer with valid/ready handshakes and a registered output.
//   Selects among N_CH input streams by round-robin or fixed-priority arbitration.
//   Presents one W-bit word per transfer on a single output stream.
//   Sits between several data producers and one shared consumer (e.g. a shared bus or FIFO).
//
// PARAMETERS
//   N_CH       4   number of input channels, >= 2
//   W          4   data width per channel, in bits
//   FIXED_PRIO 0   0 = round-robin arbitration; 1 = fixed priority, ch0 highest
//
// PORTS
//   clk        in   1            clock; all state updates on the rising edge
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   N_CH         per-channel word-valid flag
//   in_ready   out  N_CH         per-channel word-accepted flag
//   in_data    in   N_CH*W       channel i occupies bits [i*W +: W]
//   out_valid  out  1            output register holds a word
//   out_ready  in   1            consumer accepts the word this cycle
//   out_data   out  W            registered data word
//   out_sel    out  $clog2(N_CH) channel index the word came from
//
// BEHAVIOUR
//   - Reset values (async, rst_n low): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
//   - Transfer rule: a transfer occurs on an edge where valid && ready are both high.
//     This applies to each input channel and to the output.
//   - Input rules:
//     - in_valid must not depend on in_ready.
//     - Once raised, in_valid/in_data stay stable until accepted.
//   - load = !out_valid || out_ready. The output register refills in the same cycle it drains,
//     so the block sustains full throughput.
//   - Grant (combinational, one-hot or zero):
//     - Round-robin: first asserted in_valid found searching from rr_ptr upward, wrapping N_CH-1 -> 0.
//     - Fixed priority: lowest-index asserted in_valid.
//   - in_ready[i] = load && grant[i]. At most one in_ready is high per cycle.
//     in_ready is never high for a channel whose in_valid is low.
//   - On an edge with load:
//     - Some channel g granted: out_valid<=1, out_data<=in_data[g], out_sel<=g.
//       In round-robin mode, rr_ptr<=(g+1) mod N_CH.
//     - No channel granted: out_valid<=0; out_data and out_sel hold their values.
//   - On an edge without load (stall): out_valid, out_data, out_sel and rr_ptr all hold.
//   - Latency: 1 cycle from input transfer to out_valid.
//   - rr_ptr changes only on a grant. It is unused when FIXED_PRIO=1.
//   - Output register state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
//     - EMPTY -> FULL on any grant.
//     - FULL -> FULL on a stall, or on drain + grant.
//     - FULL -> EMPTY on drain with no grant.
//   - X-isolation: data of non-granted channels must never reach out_data.
//     An X on an idle channel's in_data is legal.
//   - Reset mid-operation: any buffered word is dropped, no in_ready is asserted while rst_n is low,
//     and arbitration restarts from ch0.
//
// STRUCTURE
//   - Package stream_mux_pkg holds:
//     - localparam function clog2_min1(n), returning at least 1;
//     - typedef for the channel-index type.
//   - One sub-module, rr_arbiter #(N, FIXED_PRIO):
//     - inputs: req[N], ptr, advance;
//     - outputs: one-hot grant[N], grant index, any_grant;
//     - it owns rr_ptr.
//   - Top level contains the output register, the load logic and a one-hot AND-OR data select.
//     The select is not an indexed part-select, which gives the X-isolation above.
//
// TESTING
//   1. Reset: rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0000, out_data=0.
//      After release, the first grant goes to ch0.
//   2. Round-robin fairness: N_CH=4, W=4, data a/b/c/d on ch0..3, all valid, out_ready=1.
//      -> out_data a,b,c,d,a,... one word per cycle; out_sel 0,1,2,3,0.
//   3. Skip idle and wrap: only ch1 and ch3 valid, starting rr_ptr=2 -> ch3 (sel 3), then ch1 (sel 1), then ch3.
//      ch3 carries 'x data while ch1 is granted -> out_data never X.
//   4. Back-pressure: out_ready=0 for 3 cycles while out_valid=1.
//      -> out_data/out_sel stable, in_ready=0 on all channels.
//      out_ready=1 -> the next word is loaded in the same cycle.
//   5. Fixed priority: FIXED_PRIO=1, ch0=7 and ch2=3 continuously valid -> ch0 (7) wins every cycle.
//      Drop ch0 -> ch2 (3) is granted.
//   6. Reset mid-stream: assert rst_n=0 while out_valid=1, out_ready=0 -> out_valid falls asynchronously.
//      No input transfer is counted, and arbitration restarts at ch0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer.
// Index width helper and channel-index type.
package stream_mux_pkg;

  localparam int DEF_N_CH = 4;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IW = clog2_min1(DEF_N_CH);

  typedef logic [DEF_IW-1:0] ch_idx_t;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin / fixed-priority arbiter.
// Owns the rotation pointer; grants are one-hot or zero.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N          = 4,
  parameter int FIXED_PRIO = 0,
  parameter int IW         = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx,
  output logic          any_grant
);

  logic [IW-1:0] rr_ptr;
  logic [N-1:0]  hi;
  logic [N-1:0]  pick;

  // requests at or above the pointer win; else wrap to the lowest
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++)
      hi[i] = req[i] && (FIXED_PRIO == 0) && (i >= int'(rr_ptr));
    pick  = (|hi) ? hi : req;
    grant = '0;
    gidx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gidx     = IW'(i);
      end
    end
    any_grant = |req;
  end

  // pointer moves past the winner only when a word is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (advance && any_grant && FIXED_PRIO == 0)
      rr_ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer.
// Registered output, refills in the cycle it drains.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int W          = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH*W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(N_CH)-1:0] out_sel
);

  localparam int IW = clog2_min1(N_CH);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state;
  logic            load;
  logic [N_CH-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            any_grant;
  logic [W-1:0]    sel_data;

  rr_arbiter #(
    .N          (N_CH),
    .FIXED_PRIO (FIXED_PRIO),
    .IW         (IW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (load),
    .grant     (grant),
    .gidx      (gidx),
    .any_grant (any_grant)
  );

  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;
  assign in_ready  = grant & {N_CH{load && rst_n}};

  // AND-OR select keeps idle-channel data off the output
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++)
      sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
  end

  // output register: EMPTY/FULL with hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
    end else if (load) begin
      if (any_grant) begin
        state    <= FULL;
        out_data <= sel_data;
        out_sel  <= gidx;
      end else begin
        state    <= EMPTY;
      end
    end
  end

endmodule
